fetch_stage_reg: RTL and testbench



---
 rtl/fetch_stage_reg_pkg.sv | 67 ++++++
 rtl/fetch_stage_reg_if.sv | 31 +++
 rtl/fetch_stage_reg_skid.sv | 30 +++
 rtl/fetch_stage_reg.sv | 117 +++++++++++
 tb/tb_fetch_stage_reg.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_reg_pkg.sv
// rtl/fetch_stage_reg_pkg.sv - fetch_pkg: default sizes, fetch bundle type and lane expansion helper
package fetch_pkg;

   localparam int FETCH_WIDTH_DEF = 2;
   localparam int PC_W_DEF        = 32;

   // Bundle is sized for the largest legal configuration (8 lanes, 64-bit PC)
   // so one type serves every instance; callers slice what they need.
   localparam int FETCH_W_MAX = 8;
   localparam int PC_W_MAX    = 64;
   localparam int LANE_W_MAX  = 3;

   typedef struct packed {
      logic [FETCH_W_MAX-1:0][PC_W_MAX-1:0] lane_pc;
      logic [FETCH_W_MAX-1:0]               lane_valid;
      logic                                 pred_taken;
   } fetch_bundle_t;

   // Lane index width: ceil(log2(fetch_width)), never below one bit.
   function automatic int lane_bits(input int fetch_width);
      int lw;
      lw = 0;
      for (int k = 0; k < LANE_W_MAX; k++) begin
         if ((1 << lw) < fetch_width) lw++;
      end
      return (lw < 1) ? 1 : lw;
   endfunction

   // Expand one fetch PC into per-lane PCs and the lane-valid mask.
   // Lanes below the entry offset are dead; lanes after a predicted-taken
   // branch are dead; a prediction below the entry offset is stale and dropped.
   function automatic fetch_bundle_t make_bundle(
      input logic [PC_W_MAX-1:0]   pc,
      input logic                  pred_taken,
      input logic [LANE_W_MAX-1:0] pred_lane,
      input int                    fetch_width,
      input int                    pc_w
   );
      fetch_bundle_t         b;
      logic [PC_W_MAX-1:0]   pc_mask;
      logic [PC_W_MAX-1:0]   lane_mask;
      logic [PC_W_MAX-1:0]   base;
      logic [LANE_W_MAX-1:0] off;
      logic [LANE_W_MAX-1:0] lane;
      logic [LANE_W_MAX-1:0] idx;
      logic                  eff_taken;

      b         = '0;
      pc_mask   = (pc_w >= PC_W_MAX) ? '1 : ((64'd1 << pc_w) - 64'd1);
      lane_mask = 64'(fetch_width - 1);
      base      = pc & pc_mask & ~((64'd1 << (2 + lane_bits(fetch_width))) - 64'd1);
      off       = (fetch_width == 1) ? '0 : LANE_W_MAX'((pc >> 2) & lane_mask);
      lane      = pred_lane & LANE_W_MAX'(lane_mask);
      eff_taken = pred_taken && (lane >= off);

      for (int i = 0; i < FETCH_W_MAX; i++) begin
         if (i < fetch_width) begin
            idx             = LANE_W_MAX'(i);
            b.lane_pc[i]    = (base + 64'(4 * i)) & pc_mask;
            b.lane_valid[i] = (idx >= off) && (!eff_taken || (idx <= lane));
         end
      end
      b.pred_taken = eff_taken;
      return b;
   endfunction

endpackage

// File: rtl/fetch_stage_reg_if.sv
// rtl/fetch_stage_reg_if.sv - IF1 -> stage -> IF2 handshake bundle with master/slave views
interface fetch_stage_reg_if #(
   parameter int FETCH_WIDTH = fetch_pkg::FETCH_WIDTH_DEF,
   parameter int PC_W        = fetch_pkg::PC_W_DEF
);
   localparam int LANE_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

   logic                        in_valid;
   logic                        in_ready;
   logic [PC_W-1:0]             in_pc;
   logic                        in_pred_taken;
   logic [LANE_W-1:0]           in_pred_lane;

   logic                        out_valid;
   logic                        out_ready;
   logic [FETCH_WIDTH*PC_W-1:0] out_lane_pc;
   logic [FETCH_WIDTH-1:0]      out_lane_valid;
   logic                        out_pred_taken;

   // Surrounding pipeline: IF1 drives requests, IF2 drives out_ready.
   modport master (
      output in_valid, in_pc, in_pred_taken, in_pred_lane, out_ready,
      input  in_ready, out_valid, out_lane_pc, out_lane_valid, out_pred_taken
   );

   // The pipeline register itself.
   modport slave (
      input  in_valid, in_pc, in_pred_taken, in_pred_lane, out_ready,
      output in_ready, out_valid, out_lane_pc, out_lane_valid, out_pred_taken
   );
endinterface

// File: rtl/fetch_stage_reg_skid.sv
// rtl/fetch_stage_reg_skid.sv - fetch_skid_slot: one-entry holding buffer with flush
module fetch_skid_slot #(
   parameter int DW = 1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] push_data,
   output logic          full,
   output logic [DW-1:0] data
);

   // Capture on push, release on pop; flush discards the held entry.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         full <= 1'b0;
         data <= '0;
      end else if (flush) begin
         full <= 1'b0;
      end else if (push) begin
         full <= 1'b1;
         data <= push_data;
      end else if (pop) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage_reg.sv
// rtl/fetch_stage_reg.sv - IF1->IF2 fetch pipeline register; optional skid slot under FETCH_SKID_EN
module fetch_stage_reg
   import fetch_pkg::*;
#(
   parameter int FETCH_WIDTH = FETCH_WIDTH_DEF,
   parameter int PC_W        = PC_W_DEF
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             flush,
   fetch_stage_reg_if.slave bus
);

   localparam int LANE_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

   logic                        in_ready_w;
   logic                        accept;
   logic                        load;

   logic                        out_valid_q;
   logic [FETCH_WIDTH*PC_W-1:0] lane_pc_q;
   logic [FETCH_WIDTH-1:0]      lane_valid_q;
   logic                        pred_q;

   logic [FETCH_WIDTH*PC_W-1:0] ld_pc;
   logic [FETCH_WIDTH-1:0]      ld_mask;
   logic                        ld_pt;

   fetch_bundle_t               nb;
   logic [FETCH_WIDTH*PC_W-1:0] nb_pc;
   logic [FETCH_WIDTH-1:0]      nb_mask;
   logic                        nb_pt;
   logic                        unused_nb;

   // Expand the incoming fetch PC into the lane bundle and flatten it to this instance's widths.
   always_comb begin
      nb      = make_bundle(PC_W_MAX'(bus.in_pc), bus.in_pred_taken,
                            LANE_W_MAX'(bus.in_pred_lane), FETCH_WIDTH, PC_W);
      nb_pc   = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         nb_pc[i*PC_W +: PC_W] = nb.lane_pc[i][PC_W-1:0];
      end
      nb_mask = nb.lane_valid[FETCH_WIDTH-1:0];
      nb_pt   = nb.pred_taken;
   end

   // Lanes/bits above this instance's configuration are never used.
   assign unused_nb = ^nb;

   // A flush kills the same-cycle input regardless of the handshake.
   assign accept = bus.in_valid && in_ready_w && !flush;

`ifdef FETCH_SKID_EN
   localparam int BW = FETCH_WIDTH*PC_W + FETCH_WIDTH + 1;

   logic          out_free;
   logic          skid_full;
   logic          skid_push;
   logic          skid_pop;
   logic [BW-1:0] skid_data;

   // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
   assign out_free   = !out_valid_q || bus.out_ready;
   assign in_ready_w = !skid_full;
   assign skid_push  = accept && !out_free;
   assign skid_pop   = skid_full && out_free;
   assign load       = skid_pop || (accept && out_free);

   fetch_skid_slot #(.DW(BW)) u_skid (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (flush),
      .push      (skid_push),
      .pop       (skid_pop),
      .push_data ({nb_pc, nb_mask, nb_pt}),
      .full      (skid_full),
      .data      (skid_data)
   );

   // The skid entry is older than anything on the input, so it always goes first.
   assign {ld_pc, ld_mask, ld_pt} = skid_full ? skid_data : {nb_pc, nb_mask, nb_pt};
`else
   assign in_ready_w = !out_valid_q || bus.out_ready;
   assign load       = accept;
   assign {ld_pc, ld_mask, ld_pt} = {nb_pc, nb_mask, nb_pt};
`endif

   // Output stage: flush clears, load refills, a taken bundle empties; otherwise hold.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid_q  <= 1'b0;
         lane_pc_q    <= '0;
         lane_valid_q <= '0;
         pred_q       <= 1'b0;
      end else if (flush) begin
         out_valid_q  <= 1'b0;
         lane_valid_q <= '0;
         pred_q       <= 1'b0;
      end else if (load) begin
         out_valid_q  <= 1'b1;
         lane_pc_q    <= ld_pc;
         lane_valid_q <= ld_mask;
         pred_q       <= ld_pt;
      end else if (bus.out_ready) begin
         out_valid_q  <= 1'b0;
         lane_valid_q <= '0;
         pred_q       <= 1'b0;
      end
   end

   assign bus.in_ready       = in_ready_w;
   assign bus.out_valid      = out_valid_q;
   assign bus.out_lane_pc    = lane_pc_q;
   assign bus.out_lane_valid = lane_valid_q;
   assign bus.out_pred_taken = pred_q;

endmodule

// File: tb/tb_fetch_stage_reg.sv
// tb/tb_fetch_stage_reg.sv - self-checking bench for fetch_stage_reg (2- and 4-lane instances)
module tb_fetch_stage_reg;

   logic clk    = 1'b0;
   logic rstn   = 1'b0;
   logic flush2 = 1'b0;
   logic flush4 = 1'b0;

   always #5 clk = ~clk;

   fetch_stage_reg_if #(.FETCH_WIDTH(2), .PC_W(32)) b2 ();
   fetch_stage_reg_if #(.FETCH_WIDTH(4), .PC_W(32)) b4 ();

   fetch_stage_reg #(.FETCH_WIDTH(2), .PC_W(32)) dut2 (
      .clk(clk), .rstn(rstn), .flush(flush2), .bus(b2.slave));
   fetch_stage_reg #(.FETCH_WIDTH(4), .PC_W(32)) dut4 (
      .clk(clk), .rstn(rstn), .flush(flush4), .bus(b4.slave));

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [255:0] pcs;
      logic [7:0]   mask;
      logic         pt;
   } exp_t;

   task automatic set_in(input int w, input logic v, input logic [31:0] pc, input logic t,
                         input int lane, input logic ordy, input logic fl);
      if (w == 2) begin
         b2.in_valid = v; b2.in_pc = pc; b2.in_pred_taken = t;
         b2.in_pred_lane = 1'(lane); b2.out_ready = ordy; flush2 = fl;
      end else begin
         b4.in_valid = v; b4.in_pc = pc; b4.in_pred_taken = t;
         b4.in_pred_lane = 2'(lane); b4.out_ready = ordy; flush4 = fl;
      end
   endtask

   task automatic get_out(input int w, output logic ov, output logic ir, output logic [255:0] pcs,
                          output logic [7:0] mask, output logic pt);
      pcs = '0;
      if (w == 2) begin
         ov = b2.out_valid; ir = b2.in_ready; pcs[63:0] = b2.out_lane_pc;
         mask = {6'b0, b2.out_lane_valid}; pt = b2.out_pred_taken;
      end else begin
         ov = b4.out_valid; ir = b4.in_ready; pcs[127:0] = b4.out_lane_pc;
         mask = {4'b0, b4.out_lane_valid}; pt = b4.out_pred_taken;
      end
   endtask

   // Reference: base = PC rounded down to the block, lane i = base + 4i (32-bit wrap),
   // entry offset = word index within the block, stale predictions dropped.
   function automatic void model_bundle(input int w, input logic [31:0] pc, input logic taken,
                                        input int lane, output logic [255:0] pcs,
                                        output logic [7:0] mask, output logic pt);
      int lw, off;
      logic [31:0] base, p;
      lw   = (w <= 2) ? 1 : ((w <= 4) ? 2 : 3);
      base = (pc >> (2 + lw)) << (2 + lw);
      off  = (w == 1) ? 0 : int'((pc >> 2) % w);
      pt   = taken && (lane >= off);
      pcs  = '0;
      mask = '0;
      for (int i = 0; i < w; i++) begin
         p = base + 32'(4 * i);
         pcs[i*32 +: 32] = p;
         mask[i] = (i >= off) && (!pt || i <= lane);
      end
   endfunction

   task automatic clear(input int w);
      @(negedge clk); set_in(w, 0, 0, 0, 0, 1, 1);
      @(negedge clk); set_in(w, 0, 0, 0, 0, 1, 0);
   endtask

   task automatic test_reset();
      logic ov, ir, pt; logic [255:0] pcs; logic [7:0] mask;
      rstn = 1'b0;
      set_in(2, 0, 0, 0, 0, 0, 0);
      set_in(4, 0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      for (int w = 2; w <= 4; w += 2) begin
         get_out(w, ov, ir, pcs, mask, pt);
         n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid w%0d: got %b want 0", w, ov); end
         n_cmp++; if (mask !== 8'h00) begin n_bad++; $display("FAIL reset_lane_valid w%0d: got %h want 00", w, mask); end
         n_cmp++; if (pcs !== 256'h0) begin n_bad++; $display("FAIL reset_lane_pc w%0d: got %h want 0", w, pcs); end
         n_cmp++; if (pt !== 1'b0) begin n_bad++; $display("FAIL reset_pred_taken w%0d: got %b want 0", w, pt); end
         n_cmp++; if (ir !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready w%0d: got %b want 1", w, ir); end
      end
      rstn = 1'b1;
   endtask

   task automatic test_aligned_w2();
      logic ov, ir, pt; logic [255:0] pcs, want; logic [7:0] mask;
      clear(2);
      want = '0; want[31:0] = 32'h0000_1C00; want[63:32] = 32'h0000_1C04;
      @(negedge clk); set_in(2, 1, 32'h0000_1C00, 0, 0, 1, 0);
      @(negedge clk); set_in(2, 0, 0, 0, 0, 1, 0); #1;
      get_out(2, ov, ir, pcs, mask, pt);
      n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL aligned_out_valid: got %b want 1", ov); end
      n_cmp++; if (pcs !== want) begin n_bad++; $display("FAIL aligned_lane_pc: got %h want %h", pcs[63:0], want[63:0]); end
      n_cmp++; if (mask !== 8'h03) begin n_bad++; $display("FAIL aligned_lane_valid: got %h want 03", mask); end
      n_cmp++; if (pt !== 1'b0) begin n_bad++; $display("FAIL aligned_pred_taken: got %b want 0", pt); end
      @(negedge clk); #1;
      get_out(2, ov, ir, pcs, mask, pt);
      n_cmp++; if (ov !== 1'b0 || mask !== 8'h00) begin n_bad++; $display("FAIL aligned_drain: got valid %b mask %h want 0/00", ov, mask); end
   endtask

   // Misaligned entry, ignored prediction and address wrap, issued back to back.
   task automatic test_lane_mask_w4();
      logic ov, ir, pt; logic [255:0] pcs, want; logic [7:0] mask;
      logic [31:0] tpc   [3] = '{32'h0000_2008, 32'h0000_200C, 32'hFFFF_FFF8};
      logic        ttk   [3] = '{1'b1, 1'b1, 1'b0};
      int          tln   [3] = '{3, 1, 0};
      logic [7:0]  tmask [3] = '{8'h0C, 8'h08, 8'h0C};
      logic        tpt   [3] = '{1'b1, 1'b0, 1'b0};
      logic [31:0] tbase [3] = '{32'h0000_2000, 32'h0000_2000, 32'hFFFF_FFF0};
      clear(4);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k < 3) set_in(4, 1, tpc[k], ttk[k], tln[k], 1, 0);
         else       set_in(4, 0, 0, 0, 0, 1, 0);
         #1;
         if (k > 0) begin
            get_out(4, ov, ir, pcs, mask, pt);
            want = '0;
            for (int i = 0; i < 4; i++) want[i*32 +: 32] = tbase[k-1] + 32'(4 * i);
            n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL w4_case%0d_out_valid: got %b want 1", k-1, ov); end
            n_cmp++; if (pcs !== want) begin n_bad++; $display("FAIL w4_case%0d_lane_pc: got %h want %h", k-1, pcs[127:0], want[127:0]); end
            n_cmp++; if (mask !== tmask[k-1]) begin n_bad++; $display("FAIL w4_case%0d_lane_valid: got %h want %h", k-1, mask, tmask[k-1]); end
            n_cmp++; if (pt !== tpt[k-1]) begin n_bad++; $display("FAIL w4_case%0d_pred_taken: got %b want %b", k-1, pt, tpt[k-1]); end
         end
      end
   endtask

   task automatic test_stall_flush();
      logic ov, ir, pt; logic [255:0] pcs, want; logic [7:0] mask;
      clear(2);
      want = '0; want[31:0] = 32'h0000_3000; want[63:32] = 32'h0000_3004;
      @(negedge clk); set_in(2, 1, 32'h0000_3000, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); set_in(2, 1, 32'h0000_4000, 0, 0, 0, (k == 2)); #1;
         get_out(2, ov, ir, pcs, mask, pt);
         n_cmp++; if (ov !== 1'b1 || pcs !== want || mask !== 8'h03) begin
            n_bad++; $display("FAIL stall_hold c%0d: got valid %b pc %h mask %h want 1 %h 03", k, ov, pcs[63:0], mask, want[63:0]);
         end
`ifndef FETCH_SKID_EN
         n_cmp++; if (ir !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready c%0d: got %b want 0", k, ir); end
`endif
      end
      @(negedge clk); set_in(2, 0, 0, 0, 0, 1, 0); #1;
      get_out(2, ov, ir, pcs, mask, pt);
      n_cmp++; if (ov !== 1'b0 || mask !== 8'h00) begin n_bad++; $display("FAIL flush_clear: got valid %b mask %h want 0/00", ov, mask); end
      @(negedge clk); #1;
      get_out(2, ov, ir, pcs, mask, pt);
      n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL flush_input_dropped: got valid %b want 0", ov); end
   endtask

   task automatic test_async_reset();
      logic ov, ir, pt; logic [255:0] pcs; logic [7:0] mask;
      clear(4);
      @(negedge clk); set_in(4, 1, 32'h0000_7004, 1, 3, 0, 0);
      @(negedge clk); set_in(4, 0, 0, 0, 0, 0, 0); #1;
      get_out(4, ov, ir, pcs, mask, pt);
      n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL areset_pre_valid: got %b want 1", ov); end
      #2 rstn = 1'b0;
      #1 get_out(4, ov, ir, pcs, mask, pt);
      n_cmp++; if (ov !== 1'b0 || mask !== 8'h00 || pcs !== 256'h0 || pt !== 1'b0) begin
         n_bad++; $display("FAIL areset_clear: got valid %b mask %h pt %b pc %h want all 0", ov, mask, pt, pcs[127:0]);
      end
      n_cmp++; if (ir !== 1'b1) begin n_bad++; $display("FAIL areset_in_ready: got %b want 1", ir); end
      @(negedge clk); rstn = 1'b1;
      set_in(4, 0, 0, 0, 0, 1, 0);
   endtask

`ifdef FETCH_SKID_EN
   task automatic test_skid();
      logic ov, ir, pt; logic [255:0] pcs, wa, wb; logic [7:0] mask;
      clear(2);
      wa = '0; wa[31:0] = 32'h0000_5000; wa[63:32] = 32'h0000_5004;
      wb = '0; wb[31:0] = 32'h0000_6000; wb[63:32] = 32'h0000_6004;
      @(negedge clk); set_in(2, 1, 32'h0000_5000, 0, 0, 1, 0);
      @(negedge clk); set_in(2, 1, 32'h0000_6004, 0, 0, 0, 0); #1;
      get_out(2, ov, ir, pcs, mask, pt);
      n_cmp++; if (ir !== 1'b1) begin n_bad++; $display("FAIL skid_ready_b: got %b want 1", ir); end
      @(negedge clk); set_in(2, 0, 0, 0, 0, 0, 0); #1;
      get_out(2, ov, ir, pcs, mask, pt);
      n_cmp++; if (ir !== 1'b0) begin n_bad++; $display("FAIL skid_full_ready: got %b want 0", ir); end
      n_cmp++; if (ov !== 1'b1 || pcs !== wa) begin n_bad++; $display("FAIL skid_hold_a: got %b %h want 1 %h", ov, pcs[63:0], wa[63:0]); end
      @(negedge clk); set_in(2, 0, 0, 0, 0, 1, 0); #1;
      get_out(2, ov, ir, pcs, mask, pt);
      n_cmp++; if (ov !== 1'b1 || pcs !== wa || mask !== 8'h03) begin n_bad++; $display("FAIL skid_out_a: got %b %h %h want 1 %h 03", ov, pcs[63:0], mask, wa[63:0]); end
      @(negedge clk); #1;
      get_out(2, ov, ir, pcs, mask, pt);
      n_cmp++; if (ov !== 1'b1 || pcs !== wb || mask !== 8'h02) begin n_bad++; $display("FAIL skid_out_b: got %b %h %h want 1 %h 02", ov, pcs[63:0], mask, wb[63:0]); end
      n_cmp++; if (ir !== 1'b1) begin n_bad++; $display("FAIL skid_ready_after: got %b want 1", ir); end
      @(negedge clk); #1;
      get_out(2, ov, ir, pcs, mask, pt);
      n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL skid_no_dup: got valid %b want 0", ov); end
   endtask
`endif

   task automatic test_random(input int w, input int n);
      exp_t q[$];
      exp_t e;
      logic ov, ir, pt, v, t, ordy, fl, exp_ir;
      logic [255:0] pcs;
      logic [7:0] mask;
      logic [31:0] pc;
      int lane;
      clear(w);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         v    = ($urandom_range(0, 3) != 0);
         pc   = $urandom();
         t    = 1'($urandom_range(0, 1));
         lane = int'($urandom_range(0, w - 1));
         ordy = ($urandom_range(0, 9) < 7);
         fl   = ($urandom_range(0, 19) == 0);
         set_in(w, v, pc, t, lane, ordy, fl);
         #1;
         get_out(w, ov, ir, pcs, mask, pt);
`ifdef FETCH_SKID_EN
         exp_ir = (q.size() < 2);
`else
         exp_ir = (q.size() == 0) || ordy;
`endif
         n_cmp++; if (ov !== (q.size() > 0)) begin n_bad++; $display("FAIL rnd_w%0d_out_valid c%0d: got %b want %b", w, c, ov, (q.size() > 0)); end
         n_cmp++; if (ir !== exp_ir) begin n_bad++; $display("FAIL rnd_w%0d_in_ready c%0d: got %b want %b", w, c, ir, exp_ir); end
         if (q.size() > 0) begin
            n_cmp++; if (pcs !== q[0].pcs) begin n_bad++; $display("FAIL rnd_w%0d_lane_pc c%0d: got %h want %h", w, c, pcs[127:0], q[0].pcs[127:0]); end
            n_cmp++; if (mask !== q[0].mask || pt !== q[0].pt) begin
               n_bad++; $display("FAIL rnd_w%0d_mask_pred c%0d: got %h/%b want %h/%b", w, c, mask, pt, q[0].mask, q[0].pt);
            end
         end else begin
            n_cmp++; if (mask !== 8'h00) begin n_bad++; $display("FAIL rnd_w%0d_idle_mask c%0d: got %h want 00", w, c, mask); end
         end
         if (fl) begin
            q.delete();
         end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (v && exp_ir) begin
               model_bundle(w, pc, t, lane, e.pcs, e.mask, e.pt);
               q.push_back(e);
            end
         end
      end
      clear(w);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_aligned_w2();
      test_lane_mask_w4();
      test_stall_flush();
      test_async_reset();
`ifdef FETCH_SKID_EN
      test_skid();
`endif
      test_random(2, 400);
      test_random(4, 400);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
